// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired x0, two write ports,
// same-cycle write-to-read bypass, pending-write scoreboard and post-reset clear sweep.
module regfile_mp #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NREAD = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic                              ready,
    input  logic [NREAD*$clog2(NREGS)-1:0]    ra,
    output logic [NREAD*XLEN-1:0]             rdata,
    output logic [NREAD-1:0]                  rbusy,
    input  logic                              we0,
    input  logic [$clog2(NREGS)-1:0]          wa0,
    input  logic [XLEN-1:0]                   wd0,
    input  logic                              we1,
    input  logic [$clog2(NREGS)-1:0]          wa1,
    input  logic [XLEN-1:0]                   wd1,
    input  logic                              claim_en,
    input  logic [$clog2(NREGS)-1:0]          claim_addr
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
    logic [NREGS-1:0]  pend_q, pend_d;
    logic [XLEN-1:0]   regs_q [1:NREGS-1];
    logic [XLEN-1:0]   regs_d [1:NREGS-1];

    logic wr0_ok, wr1_ok;

    assign ready  = (state_q == RUN);
    assign wr0_ok = ready && we0 && (wa0 != '0);
    assign wr1_ok = ready && we1 && (wa1 != '0);

    // Register contents are not reset; the CLEAR sweep zeroes them one per cycle.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        pend_d    = pend_q;
        regs_d    = regs_q;
        if (reset) begin
            state_d   = CLEAR;
            clr_ptr_d = AW'(1);
            pend_d    = '0;
        end else if (state_q == CLEAR) begin
            regs_d[clr_ptr_q] = '0;
            clr_ptr_d         = clr_ptr_q + AW'(1);
            if (clr_ptr_q == AW'(NREGS - 1)) begin
                state_d = RUN;
            end
        end else begin
            if (wr0_ok) begin
                regs_d[wa0] = wd0;
                pend_d[wa0] = 1'b0;
            end
            if (wr1_ok) begin
                regs_d[wa1] = wd1;
                pend_d[wa1] = 1'b0;
            end
            // A claim issued alongside a write to the same register wins.
            if (claim_en && (claim_addr != '0)) begin
                pend_d[claim_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_ptr_q <= clr_ptr_d;
        pend_q    <= pend_d;
        regs_q    <= regs_d;
    end

    // Read ports: port 1 bypass has priority over port 0, then the stored value.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NREAD; k++) begin
            logic [AW-1:0] addr;
            logic          hit0, hit1;
            addr = ra[k*AW +: AW];
            hit0 = wr0_ok && (wa0 == addr);
            hit1 = wr1_ok && (wa1 == addr);
            if (ready && (addr != '0)) begin
                if (hit1) begin
                    rdata[k*XLEN +: XLEN] = wd1;
                end else if (hit0) begin
                    rdata[k*XLEN +: XLEN] = wd0;
                end else begin
                    rdata[k*XLEN +: XLEN] = regs_q[addr];
                end
                rbusy[k] = pend_q[addr] && !hit0 && !hit1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: a default 64x32/2-port build
// and a small 32x8/3-port build share one clock.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset;

    // Default build: XLEN=64, NREGS=32, NREAD=2
    logic [4:0]   ra0, ra1;
    logic [9:0]   ra;
    logic [127:0] rdata;
    logic [1:0]   rbusy;
    logic         ready;
    logic         we0, we1, claim_en;
    logic [4:0]   wa0, wa1, claim_addr;
    logic [63:0]  wd0, wd1;

    // Small build: XLEN=32, NREGS=8, NREAD=3
    logic [2:0]   s_ra0, s_ra1, s_ra2;
    logic [8:0]   s_ra;
    logic [95:0]  s_rdata;
    logic [2:0]   s_rbusy;
    logic         s_ready;
    logic         s_we0, s_we1, s_claim_en;
    logic [2:0]   s_wa0, s_wa1, s_claim_addr;
    logic [31:0]  s_wd0, s_wd1;

    int n_checks = 0;
    int n_fail   = 0;

    assign ra   = {ra1, ra0};
    assign s_ra = {s_ra2, s_ra1, s_ra0};

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(64), .NREGS(32), .NREAD(2)) dut (
        .clk(clk), .reset(reset), .ready(ready), .ra(ra), .rdata(rdata), .rbusy(rbusy),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .claim_en(claim_en), .claim_addr(claim_addr)
    );

    regfile_mp #(.XLEN(32), .NREGS(8), .NREAD(3)) dut_s (
        .clk(clk), .reset(reset), .ready(s_ready), .ra(s_ra), .rdata(s_rdata), .rbusy(s_rbusy),
        .we0(s_we0), .wa0(s_wa0), .wd0(s_wd0), .we1(s_we1), .wa1(s_wa1), .wd1(s_wd1),
        .claim_en(s_claim_en), .claim_addr(s_claim_addr)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 0; wa0 = '0; wd0 = '0; we1 = 0; wa1 = '0; wd1 = '0;
        claim_en = 0; claim_addr = '0;
        s_we0 = 0; s_wa0 = '0; s_wd0 = '0; s_we1 = 0; s_wa1 = '0; s_wd1 = '0;
        s_claim_en = 0; s_claim_addr = '0;
    endtask

    initial begin
        reset = 1'b1;
        ra0 = 5'd5; ra1 = 5'd0; s_ra0 = 3'd0; s_ra1 = 3'd0; s_ra2 = 3'd0;
        idle_inputs();
        step();
        step();
        #1;
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_rdata0", rdata[63:0], 64'd0);
        check("reset_rbusy", {62'd0, rbusy}, 64'd0);
        check("reset_s_ready", {63'd0, s_ready}, 64'd0);

        reset = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            step();
            check($sformatf("clear_ready_e%0d", i), {63'd0, ready}, {63'd0, (i == 31)});
            check($sformatf("clear_s_ready_e%0d", i), {63'd0, s_ready}, {63'd0, (i >= 7)});
            if (i == 10) check("clear_read_x5", rdata[63:0], 64'd0);
        end
        #1;
        check("run_read_x5", rdata[63:0], 64'd0);

        // Write with same-cycle bypass, then from storage
        we0 = 1; wa0 = 5'd5; wd0 = 64'hDEAD; ra0 = 5'd5; ra1 = 5'd0;
        #1;
        check("bypass_x5", rdata[63:0], 64'hDEAD);
        check("port1_x0", rdata[127:64], 64'd0);
        step();
        we0 = 0;
        #1;
        check("stored_x5", rdata[63:0], 64'hDEAD);

        // Both ports hit x7: port 1 wins
        we0 = 1; wa0 = 5'd7; wd0 = 64'h11; we1 = 1; wa1 = 5'd7; wd1 = 64'h22;
        ra0 = 5'd7; ra1 = 5'd7;
        #1;
        check("dual_bypass_p0", rdata[63:0], 64'h22);
        check("dual_bypass_p1", rdata[127:64], 64'h22);
        step();
        idle_inputs();
        #1;
        check("dual_stored_x7", rdata[63:0], 64'h22);

        // x0 stays zero
        we0 = 1; wa0 = 5'd0; wd0 = 64'hFF; ra0 = 5'd0; ra1 = 5'd5;
        #1;
        check("x0_bypass", rdata[63:0], 64'd0);
        check("p1_x5_indep", rdata[127:64], 64'hDEAD);
        step();
        idle_inputs();
        #1;
        check("x0_stored", rdata[63:0], 64'd0);

        // Scoreboard: claim shows next cycle
        claim_en = 1; claim_addr = 5'd9; ra0 = 5'd9; ra1 = 5'd9;
        #1;
        check("claim_same_cycle", {62'd0, rbusy}, 64'd0);
        step();
        claim_en = 0;
        #1;
        check("claim_next_cycle", {62'd0, rbusy}, 64'd3);

        // Write + re-claim same cycle: hidden now, pending next cycle
        we1 = 1; wa1 = 5'd9; wd1 = 64'h99; claim_en = 1; claim_addr = 5'd9;
        #1;
        check("wr_claim_rbusy", {63'd0, rbusy[0]}, 64'd0);
        check("wr_claim_rdata", rdata[63:0], 64'h99);
        step();
        idle_inputs();
        #1;
        check("set_wins", {63'd0, rbusy[0]}, 64'd1);

        // Plain write clears the pending bit
        we0 = 1; wa0 = 5'd9; wd0 = 64'hA9;
        step();
        idle_inputs();
        #1;
        check("write_clears_pend", {62'd0, rbusy}, 64'd0);
        check("x9_value", rdata[63:0], 64'hA9);

        // Claim of x0 is ignored
        claim_en = 1; claim_addr = 5'd0; ra0 = 5'd0;
        step();
        idle_inputs();
        #1;
        check("claim_x0", {63'd0, rbusy[0]}, 64'd0);

        // Small build: three ports with distinct data
        s_we0 = 1; s_wa0 = 3'd1; s_wd0 = 32'h111; s_we1 = 1; s_wa1 = 3'd2; s_wd1 = 32'h222;
        step();
        idle_inputs();
        s_we0 = 1; s_wa0 = 3'd3; s_wd0 = 32'h333;
        step();
        idle_inputs();
        s_ra0 = 3'd1; s_ra1 = 3'd2; s_ra2 = 3'd3;
        #1;
        check("s_port0_x1", {32'd0, s_rdata[31:0]}, 64'h111);
        check("s_port1_x2", {32'd0, s_rdata[63:32]}, 64'h222);
        check("s_port2_x3", {32'd0, s_rdata[95:64]}, 64'h333);
        check("s_rbusy", {61'd0, s_rbusy}, 64'd0);

        // Reset mid-RUN re-zeroes contents and drops claims/writes during CLEAR
        we0 = 1; wa0 = 5'd3; wd0 = 64'h55;
        step();
        idle_inputs();
        ra0 = 5'd3; ra1 = 5'd4;
        #1;
        check("x3_before_reset", rdata[63:0], 64'h55);
        reset = 1'b1;
        step();
        reset = 1'b0;
        claim_en = 1; claim_addr = 5'd4; we0 = 1; wa0 = 5'd3; wd0 = 64'h77;
        #1;
        check("clear_bypass_blocked", rdata[63:0], 64'd0);
        for (int i = 1; i <= 30; i++) step();
        check("reclear_not_ready", {63'd0, ready}, 64'd0);
        step();
        idle_inputs();
        #1;
        check("reclear_ready", {63'd0, ready}, 64'd1);
        check("x3_rezeroed", rdata[63:0], 64'd0);
        check("claim_dropped", {63'd0, rbusy[1]}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the pipelined RISC-V core, the successor to the fixed 64-bit, 32-entry, 2-read/1-write file. It adds:
- configurable width, depth and read-port count;
- a second write port;
- a hardwired-zero x0;
- same-cycle write-to-read bypass;
- a per-register pending-write scoreboard;
- a sequenced synchronous clear after reset.

It sits between decode (read, claim) and writeback (write ports).

## Interface
- XLEN, 64, register width in bits
- NREGS, 32, number of architectural registers (power of two, ≥4); AW = $clog2(NREGS) localparam
- NREAD, 2, number of read ports (1..4)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clock clk
- ready  out  1  high once clear sequence complete (state RUN)
- ra  in  NREAD*AW  read addresses, port k at bits [k*AW +: AW]
- rdata  out  NREAD*XLEN  read data, port k at [k*XLEN +: XLEN]
- rbusy  out  NREAD  port k address has a pending (claimed, unwritten) write
- we0, wa0 (AW), wd0 (XLEN)  in  write port 0 (lower priority)
- we1, wa1 (AW), wd1 (XLEN)  in  write port 1 (higher priority)
- claim_en  in  1  mark claim_addr pending (issue of instruction writing rd)
- claim_addr  in  AW  destination being claimed

## Operation
- States: CLEAR, RUN. Reset forces CLEAR, clr_ptr=1, all pending bits 0, ready=0.
- CLEAR, reset low: each edge writes 0 to reg[clr_ptr], clr_ptr++. When clr_ptr==NREGS-1 is written, go RUN. Writes, claims ignored; rdata=0, rbusy=0.
- RUN: holds until reset. Reset mid-RUN restarts CLEAR (contents re-zeroed).
- x0: never stored/written; reads return 0, rbusy bit always 0; claims/writes to 0 ignored.
- Writes (RUN): weN with waN≠0 updates reg[waN] at edge. we0 and we1 same nonzero address: port 1 data stored.
- Read (combinational): rdata_k = 0 if ra_k==0 or not ready; else wd1 if we1&&wa1==ra_k; else wd0 if we0&&wa0==ra_k; else reg[ra_k].
- Scoreboard (RUN): valid write to addr clears pend[addr]; claim_en sets pend[claim_addr]. Same address cleared and claimed in one cycle: set wins (pend=1).
- rbusy_k = pend[ra_k] && !(write this cycle to ra_k) && ra_k≠0 — bypass hides the pending bit of a register being written now; a same-cycle claim does not show until next cycle.

## Timing
- Reset values: ready=0, rdata=0, rbusy=0, pending=0.
- Clear latency: ready rises after exactly NREGS-1 rising edges with reset low (31 for default).
- Write latency: value visible on rdata same cycle (bypass) and from reg array next cycle.
- Claim latency: rbusy reflects claim from the cycle after claim_en.
- No handshake on write ports; writer must not depend on acceptance except that writes during CLEAR are dropped.
- Pure combinational path ra/we/wa/wd -> rdata/rbusy; all other paths registered.

## Test plan
- Reset 2 cycles, release: ready low for 31 edges, high after edge 31; read x5 during and after -> 0, 0.
- RUN: we0=1, wa0=5, wd0=0xDEAD, ra0=5 same cycle -> rdata0=0xDEAD; next cycle we0=0 -> still 0xDEAD.
- we0 and we1 both to x7 (0x11, 0x22), read x7 same cycle and next cycle -> 0x22 both times; write x0=0xFF -> reads 0.
- claim x9, next cycle ra0=9 -> rbusy0=1; write x9 with claim x9 same cycle -> rbusy0=0 that cycle (bypass), 1 next cycle.
- Write x3=0x55, assert reset mid-RUN, release -> x3 reads 0 after ready; claim x4 during CLEAR -> rbusy 0 after ready.
- NREGS=8, NREAD=3, XLEN=32 build: ready after 7 edges; three ports read x1/x2/x3 after writes -> correct per-port data.
